// File: rtl/seg_7_pkg.sv
// Shared constants for the 7-segment display path: segment bit positions
// and the active-high glyph patterns (a..g = bits 6..0).
package seg_7_pkg;

   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;

   // Hex letters use the usual mixed-case forms so b and d differ from 8 and 0.
   localparam logic [6:0] SEG_HA = 7'h77;
   localparam logic [6:0] SEG_HB = 7'h1F;
   localparam logic [6:0] SEG_HC = 7'h4E;
   localparam logic [6:0] SEG_HD = 7'h3D;
   localparam logic [6:0] SEG_HE = 7'h4F;
   localparam logic [6:0] SEG_HF = 7'h47;

   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_7_decode.sv
// Combinational code-to-glyph lookup. Produces the raw active-high pattern
// and flags codes 10-15 as out of range when hex display is disabled.
module seg_7_decode
   import seg_7_pkg::*;
#(
   parameter bit HEX_EN = 1'b0
) (
   input  logic [3:0] code,
   output logic [6:0] pattern,
   output logic       out_of_range
);

   always_comb begin
      pattern      = SEG_BLANK;
      out_of_range = 1'b0;
      case (code)
         4'd0:  pattern = SEG_0;
         4'd1:  pattern = SEG_1;
         4'd2:  pattern = SEG_2;
         4'd3:  pattern = SEG_3;
         4'd4:  pattern = SEG_4;
         4'd5:  pattern = SEG_5;
         4'd6:  pattern = SEG_6;
         4'd7:  pattern = SEG_7;
         4'd8:  pattern = SEG_8;
         4'd9:  pattern = SEG_9;
         default: begin
            // Codes 10-15: letters in hex mode, otherwise blank and flagged.
            if (HEX_EN) begin
               case (code)
                  4'd10:   pattern = SEG_HA;
                  4'd11:   pattern = SEG_HB;
                  4'd12:   pattern = SEG_HC;
                  4'd13:   pattern = SEG_HD;
                  4'd14:   pattern = SEG_HE;
                  default: pattern = SEG_HF;
               endcase
            end else begin
               out_of_range = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/seg_7_proc.sv
// Registered BCD/hex to 7-segment digit driver: decodes {A,B,C,D}, applies
// display polarity and registers the result with one cycle of latency.
module seg_7_proc
   import seg_7_pkg::*;
#(
   parameter bit HEX_EN     = 1'b0,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   output logic [6:0] seg_7,
   output logic       err
);

   logic [3:0] code;
   logic [6:0] pattern;
   logic [6:0] drive;
   logic       out_of_range;

   assign code = {A, B, C, D};

   seg_7_decode #(
      .HEX_EN(HEX_EN)
   ) u_decode (
      .code        (code),
      .pattern     (pattern),
      .out_of_range(out_of_range)
   );

   // Common-anode panels want lit segments low; blank therefore becomes all ones.
   assign drive = ACTIVE_LOW ? ~pattern : pattern;

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_7 <= ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
         err   <= 1'b0;
      end else begin
         seg_7 <= drive;
         err   <= out_of_range;
      end
   end

endmodule

// File: tb/tb_seg_7_proc.sv
// Directed bench for seg_7_proc: three instances (plain, hex, active-low)
// share stimulus and are checked against hand-computed glyph tables.
module tb_seg_7_proc;

   typedef struct {
      logic       rst;
      logic [3:0] code;
      logic [6:0] seg_plain;
      logic       err_plain;
      logic [6:0] seg_hex;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a = 1'b0;
   logic       b = 1'b0;
   logic       c = 1'b0;
   logic       d = 1'b0;
   logic [6:0] seg_plain;
   logic [6:0] seg_hex;
   logic [6:0] seg_al;
   logic       err_plain;
   logic       err_hex;
   logic       err_al;

   int compared   = 0;
   int mismatched = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   seg_7_proc #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) dut_plain (
      .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
      .seg_7(seg_plain), .err(err_plain)
   );

   seg_7_proc #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) dut_hex (
      .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
      .seg_7(seg_hex), .err(err_hex)
   );

   seg_7_proc #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
      .seg_7(seg_al), .err(err_al)
   );

   // Inputs change 1 ns after a rising edge; outputs are sampled there too.
   task automatic applyStimulus(input logic r, input logic [3:0] code);
      rst = r;
      {a, b, c, d} = code;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic r, input logic [3:0] code, input logic [6:0] sp,
                         input logic ep, input logic [6:0] sh);
      vec_t v;
      v.rst = r; v.code = code; v.seg_plain = sp; v.err_plain = ep; v.seg_hex = sh;
      vecs.push_back(v);
   endtask

   initial begin
      // Reset twice with code 8 present, then sweep all sixteen codes, then code 3.
      addVec(1'b1, 4'd8,  7'h00, 1'b0, 7'h00);
      addVec(1'b1, 4'd8,  7'h00, 1'b0, 7'h00);
      addVec(1'b0, 4'd0,  7'h7E, 1'b0, 7'h7E);
      addVec(1'b0, 4'd1,  7'h30, 1'b0, 7'h30);
      addVec(1'b0, 4'd2,  7'h6D, 1'b0, 7'h6D);
      addVec(1'b0, 4'd3,  7'h79, 1'b0, 7'h79);
      addVec(1'b0, 4'd4,  7'h33, 1'b0, 7'h33);
      addVec(1'b0, 4'd5,  7'h5B, 1'b0, 7'h5B);
      addVec(1'b0, 4'd6,  7'h5F, 1'b0, 7'h5F);
      addVec(1'b0, 4'd7,  7'h70, 1'b0, 7'h70);
      addVec(1'b0, 4'd8,  7'h7F, 1'b0, 7'h7F);
      addVec(1'b0, 4'd9,  7'h7B, 1'b0, 7'h7B);
      addVec(1'b0, 4'd10, 7'h00, 1'b1, 7'h77);
      addVec(1'b0, 4'd11, 7'h00, 1'b1, 7'h1F);
      addVec(1'b0, 4'd12, 7'h00, 1'b1, 7'h4E);
      addVec(1'b0, 4'd13, 7'h00, 1'b1, 7'h3D);
      addVec(1'b0, 4'd14, 7'h00, 1'b1, 7'h4F);
      addVec(1'b0, 4'd15, 7'h00, 1'b1, 7'h47);
      addVec(1'b0, 4'd3,  7'h79, 1'b0, 7'h79);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].code);
         checkOutput($sformatf("plain_seg[%0d]", i), seg_plain, vecs[i].seg_plain);
         checkOutput($sformatf("plain_err[%0d]", i), {6'd0, err_plain}, {6'd0, vecs[i].err_plain});
         checkOutput($sformatf("hex_seg[%0d]", i), seg_hex, vecs[i].seg_hex);
         checkOutput($sformatf("hex_err[%0d]", i), {6'd0, err_hex}, 7'd0);
         checkOutput($sformatf("al_seg[%0d]", i), seg_al, ~vecs[i].seg_plain);
         checkOutput($sformatf("al_err[%0d]", i), {6'd0, err_al}, {6'd0, vecs[i].err_plain});
      end

      // Active-low spot values written out directly.
      applyStimulus(1'b0, 4'd1);
      checkOutput("al_code1", seg_al, 7'h4F);
      applyStimulus(1'b0, 4'd8);
      checkOutput("al_code8", seg_al, 7'h00);

      // Held input stays stable over several edges.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 4'd7);
         checkOutput($sformatf("hold7[%0d]", k), seg_plain, 7'h70);
      end

      // Only the value present at the edge is captured.
      applyStimulus(1'b0, 4'd6);
      {a, b, c, d} = 4'd4;
      #2;
      checkOutput("mid_no_comb_path", seg_plain, 7'h5F);
      {a, b, c, d} = 4'd9;
      @(posedge clk);
      #1;
      checkOutput("mid_change_9", seg_plain, 7'h7B);

      // Latency and reset priority: 2, then 5, then reset with 5 still present.
      applyStimulus(1'b0, 4'd2);
      checkOutput("prio_code2", seg_plain, 7'h6D);
      applyStimulus(1'b0, 4'd5);
      checkOutput("prio_code5", seg_plain, 7'h5B);
      applyStimulus(1'b1, 4'd5);
      checkOutput("prio_rst_plain", seg_plain, 7'h00);
      checkOutput("prio_rst_al", seg_al, 7'h7F);
      applyStimulus(1'b0, 4'd0);
      checkOutput("release_code0", seg_plain, 7'h7E);
      checkOutput("release_code0_al", seg_al, 7'h01);

      // Error flag is cleared by reset.
      applyStimulus(1'b0, 4'd12);
      checkOutput("err_set", {6'd0, err_plain}, 7'd1);
      applyStimulus(1'b1, 4'd12);
      checkOutput("err_rst", {6'd0, err_plain}, 7'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
